// File: rtl/alu_key_cmd_fsm.sv
// alu_key_cmd_fsm: turns debounced key presses into operand A, operand B and
// opcode entry, issues one compute request to the ALU and captures its result.
//
// Handshake: alu_valid is raised on entry to S_REQ and stays high, with
// op_a/op_b/opcode held stable, until an edge where alu_valid && alu_ready
// (request accepted). alu_valid drops on the cycle after acceptance. The
// result is taken only in S_WAIT from a one-cycle alu_res_valid strobe.
module alu_key_cmd_fsm #(
   parameter int KEY_WIDTH = 4,
   parameter int DATA_W    = 4,
   parameter int OP_W      = 3,
   parameter int RES_W     = 8
) (
   input  logic                 mclk,
   input  logic                 rst,
   input  logic [KEY_WIDTH-1:0] key_value,
   input  logic                 key_flag,
   output logic [DATA_W-1:0]    op_a,
   output logic [DATA_W-1:0]    op_b,
   output logic [OP_W-1:0]      opcode,
   output logic [1:0]           field_sel,
   output logic                 alu_valid,
   input  logic                 alu_ready,
   input  logic [RES_W-1:0]     alu_res,
   input  logic                 alu_res_valid,
   output logic [RES_W-1:0]     result,
   output logic                 result_valid,
   output logic                 busy
);

   typedef enum logic [2:0] {
      S_A    = 3'd0,
      S_B    = 3'd1,
      S_OP   = 3'd2,
      S_REQ  = 3'd3,
      S_WAIT = 3'd4
   } state_t;

   state_t             r_state;
   logic [DATA_W-1:0]  r_op_a;
   logic [DATA_W-1:0]  r_op_b;
   logic [OP_W-1:0]    r_opcode;
   logic [1:0]         r_field_sel;
   logic               r_alu_valid;
   logic [RES_W-1:0]   r_result;
   logic               r_result_valid;
   logic               r_busy;

   logic [KEY_WIDTH-1:0] w_pressed;
   logic                 w_one_key;
   logic                 w_evt;
   logic                 w_inc;
   logic                 w_dec;
   logic                 w_next;
   logic                 w_clr;

   // A key event needs exactly one pressed (low) key; releases and chords are dropped.
   assign w_pressed = ~key_value;
   assign w_one_key = (w_pressed != '0) &&
                      ((w_pressed & (w_pressed - KEY_WIDTH'(1))) == '0);
   assign w_evt     = key_flag && w_one_key;
   assign w_inc     = w_evt && w_pressed[0];
   assign w_dec     = w_evt && w_pressed[1];
   assign w_next    = w_evt && w_pressed[2];
   assign w_clr     = w_evt && w_pressed[3];

   // Single state machine: field editing, request issue, result capture; all outputs registered.
   always_ff @(posedge mclk) begin
      if (rst) begin
         r_state        <= S_A;
         r_op_a         <= '0;
         r_op_b         <= '0;
         r_opcode       <= '0;
         r_field_sel    <= 2'd0;
         r_alu_valid    <= 1'b0;
         r_result       <= '0;
         r_result_valid <= 1'b0;
         r_busy         <= 1'b0;
      end else begin
         r_result_valid <= 1'b0;
         case (r_state)
            S_A, S_B, S_OP: begin
               if (w_clr) begin
                  r_op_a      <= '0;
                  r_op_b      <= '0;
                  r_opcode    <= '0;
                  r_state     <= S_A;
                  r_field_sel <= 2'd0;
               end else if (w_next) begin
                  if (r_state == S_A) begin
                     r_state     <= S_B;
                     r_field_sel <= 2'd1;
                  end else if (r_state == S_B) begin
                     r_state     <= S_OP;
                     r_field_sel <= 2'd2;
                  end else begin
                     r_state     <= S_REQ;
                     r_field_sel <= 2'd3;
                     r_alu_valid <= 1'b1;
                     r_busy      <= 1'b1;
                  end
               end else if (w_inc || w_dec) begin
                  if (r_state == S_A) begin
                     r_op_a <= w_inc ? r_op_a + DATA_W'(1) : r_op_a - DATA_W'(1);
                  end else if (r_state == S_B) begin
                     r_op_b <= w_inc ? r_op_b + DATA_W'(1) : r_op_b - DATA_W'(1);
                  end else begin
                     r_opcode <= w_inc ? r_opcode + OP_W'(1) : r_opcode - OP_W'(1);
                  end
               end
            end
            S_REQ: begin
               // A result strobe on the acceptance edge is deliberately not looked at here.
               if (alu_ready) begin
                  r_state     <= S_WAIT;
                  r_alu_valid <= 1'b0;
               end
            end
            S_WAIT: begin
               if (alu_res_valid) begin
                  r_result       <= alu_res;
                  r_result_valid <= 1'b1;
                  r_state        <= S_A;
                  r_field_sel    <= 2'd0;
                  r_busy         <= 1'b0;
               end
            end
            default: begin
               r_state     <= S_A;
               r_field_sel <= 2'd0;
               r_alu_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign op_a         = r_op_a;
   assign op_b         = r_op_b;
   assign opcode       = r_opcode;
   assign field_sel    = r_field_sel;
   assign alu_valid    = r_alu_valid;
   assign result       = r_result;
   assign result_valid = r_result_valid;
   assign busy         = r_busy;

endmodule
